// File: rtl/neuron_input_loader_pkg.sv
// neuron_pkg: shared defaults and the loader state type for the LIF neuron
// input loader. NBYTES is the number of bus bytes that make up one frame.
package neuron_pkg;

  localparam int DEFAULT_N_STAGES = 5;
  localparam int DEFAULT_BYTE_W   = 8;
  localparam int DEFAULT_INPUTS   = 2 ** DEFAULT_N_STAGES;
  localparam int DEFAULT_NBYTES   = DEFAULT_INPUTS / DEFAULT_BYTE_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COLLECT_X = 2'd1,
    COLLECT_W = 2'd2
  } loader_state_t;

endpackage

// File: rtl/neuron_input_loader_if.sv
// neuron_input_loader_if: serial byte bus into the loader plus the committed
// frame outputs towards the neuron core. The master side is the byte source
// and frame consumer; the slave side is the loader itself.
interface neuron_input_loader_if
  import neuron_pkg::*;
#(
  parameter int INPUTS = DEFAULT_INPUTS,
  parameter int BYTE_W = DEFAULT_BYTE_W
);

  logic [BYTE_W-1:0] byte_in;
  logic              byte_valid;
  logic              load_weights;
  logic              abort;
  logic [INPUTS-1:0] x_out;
  logic [INPUTS-1:0] w_out;
  logic              x_valid;
  logic              w_valid;
  logic              busy;

  modport master (
    output byte_in, byte_valid, load_weights, abort,
    input  x_out, w_out, x_valid, w_valid, busy
  );

  modport slave (
    input  byte_in, byte_valid, load_weights, abort,
    output x_out, w_out, x_valid, w_valid, busy
  );

endinterface

// File: rtl/neuron_input_loader_byte_shift_reg.sv
// byte_shift_reg: staging shifter for one frame. Earlier bytes move towards
// the MSBs as new bytes enter at the LSB end. Only the bytes received before
// the final one need storage: shift_data combines them with the byte on the
// bus, which is exactly the full frame on the committing cycle.
module byte_shift_reg
  import neuron_pkg::*;
#(
  parameter int INPUTS = DEFAULT_INPUTS,
  parameter int BYTE_W = DEFAULT_BYTE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              shift_en,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [INPUTS-1:0] shift_data
);

  if (INPUTS > BYTE_W) begin : g_shift
    logic [INPUTS-BYTE_W-1:0] held_q;

    assign shift_data = {held_q, byte_in};

    // Hold the bytes already received; clear wins over a shift.
    always_ff @(posedge clk) begin
      if (reset || clear) begin
        held_q <= '0;
      end else if (shift_en) begin
        held_q <= shift_data[INPUTS-BYTE_W-1:0];
      end
    end
  end else begin : g_single
    assign shift_data = byte_in;
  end

endmodule

// File: rtl/neuron_input_loader.sv
// neuron_input_loader: assembles the neuron's input-spike vector (x) and
// weight vector (w) from a serial byte bus and commits each completed frame
// to a stable output register with a one-cycle valid strobe.
// Optional feature macro: LOADER_TIMEOUT_EN discards a partial frame after
// TIMEOUT idle cycles; without it a partial frame waits indefinitely.
module neuron_input_loader
  import neuron_pkg::*;
#(
  parameter int N_STAGES = DEFAULT_N_STAGES,
  parameter int BYTE_W   = DEFAULT_BYTE_W,
  parameter int TIMEOUT  = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  neuron_input_loader_if.slave  bus
);

  localparam int INPUTS = 2 ** N_STAGES;
  localparam int NBYTES = INPUTS / BYTE_W;
  localparam int CNT_W  = $clog2(NBYTES) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBYTES - 1);

  if (N_STAGES < 3 || NBYTES < 1 || TIMEOUT < 1) begin : g_param_check
    $error("neuron_input_loader: unsupported parameter combination");
  end

  loader_state_t     state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [INPUTS-1:0] x_q, w_q;
  logic [INPUTS-1:0] frame_data;
  logic              x_valid_q, w_valid_q;
  logic              commit_x, commit_w;
  logic              target_w;
  logic              accept;
  logic              discard;
  logic              timeout_hit;

  // abort beats a byte on the same cycle, so that byte is never shifted in
  assign accept  = bus.byte_valid && !bus.abort;
  assign discard = bus.abort || timeout_hit;

  byte_shift_reg #(
    .INPUTS (INPUTS),
    .BYTE_W (BYTE_W)
  ) u_stage (
    .clk        (clk),
    .reset      (reset),
    .clear      (discard),
    .shift_en   (accept),
    .byte_in    (bus.byte_in),
    .shift_data (frame_data)
  );

`ifdef LOADER_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  logic [IDLE_W-1:0] idle_cnt_q;

  assign timeout_hit = (state_q != IDLE) && !bus.byte_valid && !bus.abort &&
                       (idle_cnt_q == IDLE_W'(TIMEOUT - 1));

  // Count idle cycles inside a frame; any byte or a return to IDLE restarts it.
  always_ff @(posedge clk) begin
    if (reset || state_q == IDLE || bus.byte_valid || discard) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_q + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Next state, byte count and commit strobes; the target is latched by the
  // state on the first byte, so load_weights is ignored mid-frame.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    commit_x = 1'b0;
    commit_w = 1'b0;
    target_w = (state_q == IDLE) ? bus.load_weights : (state_q == COLLECT_W);
    if (discard) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (accept) begin
      if (cnt_q == LAST_CNT) begin
        state_d  = IDLE;
        cnt_d    = '0;
        commit_w = target_w;
        commit_x = !target_w;
      end else begin
        state_d = target_w ? COLLECT_W : COLLECT_X;
        cnt_d   = cnt_q + 1'b1;
      end
    end
  end

  // State and byte counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Committed frame registers; only the targeted vector is replaced.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q       <= '0;
      w_q       <= '0;
      x_valid_q <= 1'b0;
      w_valid_q <= 1'b0;
    end else begin
      x_valid_q <= commit_x;
      w_valid_q <= commit_w;
      if (commit_x) begin
        x_q <= frame_data;
      end
      if (commit_w) begin
        w_q <= frame_data;
      end
    end
  end

  assign bus.x_out   = x_q;
  assign bus.w_out   = w_q;
  assign bus.x_valid = x_valid_q;
  assign bus.w_valid = w_valid_q;
  assign bus.busy    = (state_q != IDLE);

endmodule

// File: tb/tb_neuron_input_loader.sv
// tb_neuron_input_loader: table-driven directed checks of the neuron input
// loader, plus hand-written reset-mid-frame and timeout sequences.
`timescale 1ns/1ps
module tb_neuron_input_loader;
  import neuron_pkg::*;

`ifdef LOADER_TIMEOUT_EN
  localparam int TB_TIMEOUT = 4;
`else
  localparam int TB_TIMEOUT = 255;
`endif

  typedef struct {
    logic        bv;
    logic        lw;
    logic        ab;
    logic [7:0]  data;
    logic [31:0] exp_x;
    logic [31:0] exp_w;
    logic        exp_xv;
    logic        exp_wv;
    logic        exp_busy;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  neuron_input_loader_if bus();

  neuron_input_loader #(
    .N_STAGES (5),
    .BYTE_W   (8),
    .TIMEOUT  (TB_TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic vec_t mk(input logic bv, input logic lw, input logic ab,
                              input logic [7:0] d, input logic [31:0] ex,
                              input logic [31:0] ew, input logic exv,
                              input logic ewv, input logic eb);
    vec_t v;
    v.bv = bv; v.lw = lw; v.ab = ab; v.data = d;
    v.exp_x = ex; v.exp_w = ew; v.exp_xv = exv; v.exp_wv = ewv; v.exp_busy = eb;
    return v;
  endfunction

  task automatic applyStimulus(input logic bv, input logic lw, input logic ab,
                               input logic [7:0] d);
    bus.byte_valid   = bv;
    bus.load_weights = lw;
    bus.abort        = ab;
    bus.byte_in      = d;
    @(posedge clk);
    #1;
  endtask

  task automatic checkField(input string tag, input logic [31:0] act,
                            input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", tag, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] ex,
                             input logic [31:0] ew, input logic exv,
                             input logic ewv, input logic eb);
    checkField({name, ".x_out"},   bus.x_out,           ex);
    checkField({name, ".w_out"},   bus.w_out,           ew);
    checkField({name, ".x_valid"}, {31'd0, bus.x_valid}, {31'd0, exv});
    checkField({name, ".w_valid"}, {31'd0, bus.w_valid}, {31'd0, ewv});
    checkField({name, ".busy"},    {31'd0, bus.busy},    {31'd0, eb});
  endtask

  initial begin
    reset            = 1'b1;
    bus.byte_valid   = 1'b0;
    bus.load_weights = 1'b0;
    bus.abort        = 1'b0;
    bus.byte_in      = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    // x frame DE AD BE EF on consecutive cycles
    vecs.push_back(mk(1,0,0,8'hDE, 32'h0, 32'h0, 0,0,1));
    vecs.push_back(mk(1,0,0,8'hAD, 32'h0, 32'h0, 0,0,1));
    vecs.push_back(mk(1,0,0,8'hBE, 32'h0, 32'h0, 0,0,1));
    vecs.push_back(mk(1,0,0,8'hEF, 32'hDEADBEEF, 32'h0, 1,0,0));
    vecs.push_back(mk(0,0,0,8'h00, 32'hDEADBEEF, 32'h0, 0,0,0));
    // w frame 01..04 with three idle cycles between bytes
    vecs.push_back(mk(1,1,0,8'h01, 32'hDEADBEEF, 32'h0, 0,0,1));
    for (int g = 0; g < 3; g++) vecs.push_back(mk(0,0,0,8'h00, 32'hDEADBEEF, 32'h0, 0,0,1));
    vecs.push_back(mk(1,0,0,8'h02, 32'hDEADBEEF, 32'h0, 0,0,1));
    for (int g = 0; g < 3; g++) vecs.push_back(mk(0,0,0,8'h00, 32'hDEADBEEF, 32'h0, 0,0,1));
    vecs.push_back(mk(1,0,0,8'h03, 32'hDEADBEEF, 32'h0, 0,0,1));
    for (int g = 0; g < 3; g++) vecs.push_back(mk(0,0,0,8'h00, 32'hDEADBEEF, 32'h0, 0,0,1));
    vecs.push_back(mk(1,0,0,8'h04, 32'hDEADBEEF, 32'h01020304, 0,1,0));
    vecs.push_back(mk(0,0,0,8'h00, 32'hDEADBEEF, 32'h01020304, 0,0,0));
    // two x frames back-to-back, 11..18
    vecs.push_back(mk(1,0,0,8'h11, 32'hDEADBEEF, 32'h01020304, 0,0,1));
    vecs.push_back(mk(1,0,0,8'h12, 32'hDEADBEEF, 32'h01020304, 0,0,1));
    vecs.push_back(mk(1,0,0,8'h13, 32'hDEADBEEF, 32'h01020304, 0,0,1));
    vecs.push_back(mk(1,0,0,8'h14, 32'h11121314, 32'h01020304, 1,0,0));
    vecs.push_back(mk(1,0,0,8'h15, 32'h11121314, 32'h01020304, 0,0,1));
    vecs.push_back(mk(1,0,0,8'h16, 32'h11121314, 32'h01020304, 0,0,1));
    vecs.push_back(mk(1,0,0,8'h17, 32'h11121314, 32'h01020304, 0,0,1));
    vecs.push_back(mk(1,0,0,8'h18, 32'h15161718, 32'h01020304, 1,0,0));
    vecs.push_back(mk(0,0,0,8'h00, 32'h15161718, 32'h01020304, 0,0,0));
    // abort after two bytes; abort with a byte drops that byte
    vecs.push_back(mk(1,0,0,8'hAA, 32'h15161718, 32'h01020304, 0,0,1));
    vecs.push_back(mk(1,0,0,8'hBB, 32'h15161718, 32'h01020304, 0,0,1));
    vecs.push_back(mk(1,0,1,8'hCC, 32'h15161718, 32'h01020304, 0,0,0));
    vecs.push_back(mk(1,0,1,8'h77, 32'h15161718, 32'h01020304, 0,0,0));
    vecs.push_back(mk(1,0,0,8'h01, 32'h15161718, 32'h01020304, 0,0,1));
    vecs.push_back(mk(1,0,0,8'h02, 32'h15161718, 32'h01020304, 0,0,1));
    vecs.push_back(mk(1,0,0,8'h03, 32'h15161718, 32'h01020304, 0,0,1));
    vecs.push_back(mk(1,0,0,8'h04, 32'h01020304, 32'h01020304, 1,0,0));
    // abort on the final byte: no commit
    vecs.push_back(mk(1,0,0,8'h55, 32'h01020304, 32'h01020304, 0,0,1));
    vecs.push_back(mk(1,0,0,8'h66, 32'h01020304, 32'h01020304, 0,0,1));
    vecs.push_back(mk(1,0,0,8'h77, 32'h01020304, 32'h01020304, 0,0,1));
    vecs.push_back(mk(1,0,1,8'h88, 32'h01020304, 32'h01020304, 0,0,0));
    vecs.push_back(mk(0,0,0,8'h00, 32'h01020304, 32'h01020304, 0,0,0));
    // load_weights raised after the first byte of an x frame
    vecs.push_back(mk(1,0,0,8'h21, 32'h01020304, 32'h01020304, 0,0,1));
    vecs.push_back(mk(1,1,0,8'h22, 32'h01020304, 32'h01020304, 0,0,1));
    vecs.push_back(mk(1,1,0,8'h23, 32'h01020304, 32'h01020304, 0,0,1));
    vecs.push_back(mk(1,1,0,8'h24, 32'h21222324, 32'h01020304, 1,0,0));
    // w frame immediately after the x commit
    vecs.push_back(mk(1,1,0,8'hA1, 32'h21222324, 32'h01020304, 0,0,1));
    vecs.push_back(mk(1,0,0,8'hA2, 32'h21222324, 32'h01020304, 0,0,1));
    vecs.push_back(mk(1,0,0,8'hA3, 32'h21222324, 32'h01020304, 0,0,1));
    vecs.push_back(mk(1,0,0,8'hA4, 32'h21222324, 32'hA1A2A3A4, 0,1,0));
    vecs.push_back(mk(0,0,0,8'h00, 32'h21222324, 32'hA1A2A3A4, 0,0,0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].bv, vecs[i].lw, vecs[i].ab, vecs[i].data);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_x, vecs[i].exp_w,
                  vecs[i].exp_xv, vecs[i].exp_wv, vecs[i].exp_busy);
    end

    // reset mid-frame clears the frame and both committed vectors
    applyStimulus(1, 0, 0, 8'h42);
    applyStimulus(1, 0, 0, 8'h43);
    checkOutput("pre_reset", 32'h21222324, 32'hA1A2A3A4, 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    applyStimulus(1, 0, 0, 8'h44);
    checkOutput("mid_reset", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    applyStimulus(1, 0, 0, 8'h51);
    applyStimulus(1, 0, 0, 8'h52);
    applyStimulus(1, 0, 0, 8'h53);
    checkOutput("post_reset_partial", 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1, 0, 0, 8'h54);
    checkOutput("post_reset_commit", 32'h51525354, 32'h0, 1'b1, 1'b0, 1'b0);

    // partial frame followed by idle cycles
    applyStimulus(1, 0, 0, 8'h61);
    applyStimulus(1, 0, 0, 8'h62);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 0, 8'h00);
      checkOutput($sformatf("idle%0d", k), 32'h51525354, 32'h0, 1'b0, 1'b0, 1'b1);
    end
    applyStimulus(0, 0, 0, 8'h00);
`ifdef LOADER_TIMEOUT_EN
    checkOutput("timeout_drop", 32'h51525354, 32'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1, 0, 0, 8'hCA);
    applyStimulus(1, 0, 0, 8'hFE);
    applyStimulus(1, 0, 0, 8'hBA);
    checkOutput("timeout_refill", 32'h51525354, 32'h0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1, 0, 0, 8'hBE);
    checkOutput("timeout_commit", 32'hCAFEBABE, 32'h0, 1'b1, 1'b0, 1'b0);
`else
    checkOutput("no_timeout", 32'h51525354, 32'h0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 10; k++) applyStimulus(0, 0, 0, 8'h00);
    checkOutput("long_wait", 32'h51525354, 32'h0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1, 0, 0, 8'hCA);
    applyStimulus(1, 0, 0, 8'hFE);
    checkOutput("resume_commit", 32'h6162CAFE, 32'h0, 1'b1, 1'b0, 1'b0);
`endif
    applyStimulus(0, 0, 0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
